// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NR_REQ writeback sources,
// with a one-entry registered write stage and read-port forwarding hits.
module regfile_wb_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NR_REQ     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic [NR_REQ-1:0]            req_valid,
    input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NR_REQ*WIDTH-1:0]      req_data,
    output logic [NR_REQ-1:0]            req_ready,
    output logic                         we,
    output logic [ADDR_WIDTH-1:0]        addrw,
    output logic [WIDTH-1:0]             dinw,
    input  logic [ADDR_WIDTH-1:0]        addra,
    input  logic [ADDR_WIDTH-1:0]        addrb,
    output logic                         fwd_a,
    output logic                         fwd_b
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addrw;
    logic [WIDTH-1:0]      r_dinw;

    logic [PTR_W:0]        w_cand;
    logic [NR_REQ-1:0]     w_shift;
    logic                  w_found;
    logic [PTR_W-1:0]      w_gidx;
    logic [NR_REQ-1:0]     w_grant;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0]      w_sel_data;
    logic [PTR_W-1:0]      w_ptr_next;

    // Search from r_ptr upward, wrapping modulo NR_REQ; first valid requester wins.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_cand  = '0;
        w_shift = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int off = 0; off < NR_REQ; off++) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(off);
            if (w_cand >= (PTR_W+1)'(NR_REQ))
                w_cand = w_cand - (PTR_W+1)'(NR_REQ);
            w_shift = req_valid >> w_cand;
            if (!w_found && w_shift[0]) begin
                w_found = 1'b1;
                w_gidx  = w_cand[PTR_W-1:0];
            end
        end
    end

    // Grants are suppressed while frozen or held in reset.
    assign w_grant   = (w_found && rst && !hold) ? (NR_REQ'(1) << w_gidx) : '0;
    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_gidx == PTR_W'(NR_REQ-1)) ? '0 : w_gidx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addrw <= '0;
            r_dinw  <= '0;
        end else if (w_xfer) begin
            r_ptr   <= w_ptr_next;
            r_we    <= (w_sel_addr != '0);
            r_addrw <= w_sel_addr;
            r_dinw  <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign we    = r_we;
    assign addrw = r_addrw;
    assign dinw  = r_dinw;

    // Staged write is not yet in the register file; readers of the same reg must bypass.
    assign fwd_a = r_we && (r_addrw == addra) && (addra != '0);
    assign fwd_b = r_we && (r_addrw == addrb) && (addrb != '0);

endmodule
